uart_rx: RTL and testbench

//   UART receiver, 8N1, LSB first; receive end of the same serial link driven by the UART

---
 rtl/uart_rx.sv | 154 +++++++++++++++
 tb/tb_uart_rx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, 1-cycle valid / framing-error pulses.
// Framing errors park in a break state until the line returns high.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Rst,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_Frame_Err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned HALF  = (CLKS_PER_BIT - 1) / 2;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic             rx_meta, rx_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       byte_q, byte_d;
  logic             dv_q, dv_d;
  logic             active_q, active_d;
  logic             ferr_q, ferr_d;

  // State, synchroniser and output registers
  always_ff @(posedge i_Clock) begin
    if (i_Rst) begin
      rx_meta  <= 1'b1;
      rx_s     <= 1'b1;
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      active_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      rx_meta  <= i_RX_Serial;
      rx_s     <= rx_meta;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      active_q <= active_d;
      ferr_q   <= ferr_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    active_d = active_q;
    dv_d     = 1'b0;
    ferr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
        if (!rx_s) begin
          state_d  = START;
          active_d = 1'b1;
        end
      end

      // Re-check the line at mid start bit to reject glitches
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = DATA;
          end else begin
            state_d  = IDLE;
            active_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Leaving at mid stop bit leaves half a bit to catch the next start edge
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          active_d = 1'b0;
          if (rx_s) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = BRK;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      BRK: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
      end
    endcase
  end

  assign o_RX_DV     = dv_q;
  assign o_RX_Byte   = byte_q;
  assign o_RX_Active = active_q;
  assign o_Frame_Err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed + randomized bench for uart_rx; the serial sender and a queue of expected
// bytes form the reference model.
module tb_uart_rx;

  localparam int CPB  = 217;
  localparam int HALF = (CPB - 1) / 2;
  localparam int LAT  = HALF + 9 * CPB + 4;

  logic       i_Clock = 1'b0;
  logic       i_Rst;
  logic       i_RX_Serial;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       o_RX_Active;
  logic       o_Frame_Err;

  int total = 0;
  int bad   = 0;

  int cyc = 0, dv_n = 0, ferr_n = 0, excl_n = 0, act_n = 0, dv_cyc = 0, fall_cyc = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_good;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_Clock    (i_Clock),
    .i_Rst      (i_Rst),
    .i_RX_Serial(i_RX_Serial),
    .o_RX_DV    (o_RX_DV),
    .o_RX_Byte  (o_RX_Byte),
    .o_RX_Active(o_RX_Active),
    .o_Frame_Err(o_Frame_Err)
  );

  always #5 i_Clock = ~i_Clock;

  // Output monitor, sampled just after each rising edge
  always @(posedge i_Clock) begin
    #1;
    cyc = cyc + 1;
    if (o_RX_DV) begin
      got_q.push_back(o_RX_Byte);
      dv_n   = dv_n + 1;
      dv_cyc = cyc;
    end
    if (o_Frame_Err) ferr_n = ferr_n + 1;
    if (o_RX_DV && o_Frame_Err) excl_n = excl_n + 1;
    if (o_RX_Active) act_n = act_n + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge i_Clock);
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serial transmitter model; abort_bit>=0 resets the DUT halfway through that data bit
  task automatic send(input logic [7:0] b, input int cpb, input logic stop, input int abort_bit);
    i_RX_Serial = 1'b0;
    fall_cyc    = cyc;
    tick(cpb);
    for (int i = 0; i < 8; i++) begin
      i_RX_Serial = b[i];
      if (i == abort_bit) begin
        tick(cpb / 2);
        i_Rst = 1'b1;
        tick(1);
        i_Rst       = 1'b0;
        i_RX_Serial = 1'b1;
        return;
      end
      tick(cpb);
    end
    i_RX_Serial = stop;
    tick(cpb);
    if (stop) begin
      i_RX_Serial = 1'b1;
      exp_q.push_back(b);
      last_good = b;
    end
  endtask

  task automatic drain(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_dv"}, o_RX_DV, 0);
    chk({tag, "_byte"}, o_RX_Byte, 0);
    chk({tag, "_active"}, o_RX_Active, 0);
    chk({tag, "_ferr"}, o_Frame_Err, 0);
  endtask

  int d0, f0, lat;
  logic [7:0] rb;
  int rc;

  initial begin
    i_Rst       = 1'b1;
    i_RX_Serial = 1'b1;
    last_good   = 8'h00;
    tick(4);
    chk_reset_vals("reset");
    i_Rst = 1'b0;
    tick(4);

    // Single byte at exact baud, with latency check
    d0 = dv_n; f0 = ferr_n;
    send(8'hA5, CPB, 1'b1, -1);
    tick(2 * CPB);
    lat = dv_cyc - fall_cyc;
    chk("t1_latency_in_window", (lat >= LAT - 1 && lat <= LAT + 1) ? 1 : 0, 1);
    chk("t1_dv_pulses", dv_n - d0, 1);
    chk("t1_byte", o_RX_Byte, 8'hA5);
    chk("t1_ferr", ferr_n - f0, 0);
    chk("t1_active_low", o_RX_Active, 0);
    drain("t1");

    // Back-to-back frames, no idle gap
    d0 = dv_n; f0 = ferr_n;
    send(8'h00, CPB, 1'b1, -1);
    send(8'hFF, CPB, 1'b1, -1);
    send(8'h5A, CPB, 1'b1, -1);
    tick(2 * CPB);
    chk("t2_dv_pulses", dv_n - d0, 3);
    chk("t2_ferr", ferr_n - f0, 0);
    drain("t2");

    // Short low glitch rejected at mid start bit
    d0 = dv_n; f0 = ferr_n; act_n = 0;
    i_RX_Serial = 1'b0;
    tick(50);
    i_RX_Serial = 1'b1;
    tick(3 * CPB);
    chk("t3_dv", dv_n - d0, 0);
    chk("t3_ferr", ferr_n - f0, 0);
    chk("t3_active_span_ok", (act_n >= 50 && act_n <= HALF + 6) ? 1 : 0, 1);
    chk("t3_active_low", o_RX_Active, 0);

    // Framing error, held break, then recovery
    d0 = dv_n; f0 = ferr_n;
    send(8'h3C, CPB, 1'b0, -1);
    tick(5 * CPB);
    chk("t4_ferr_pulses", ferr_n - f0, 1);
    chk("t4_no_dv", dv_n - d0, 0);
    chk("t4_byte_held", o_RX_Byte, last_good);
    chk("t4_active_low_in_break", o_RX_Active, 0);
    i_RX_Serial = 1'b1;
    tick(CPB);
    send(8'h81, CPB, 1'b1, -1);
    tick(2 * CPB);
    chk("t4_dv_after", dv_n - d0, 1);
    chk("t4_ferr_total", ferr_n - f0, 1);
    drain("t4");

    // Reset in the middle of data bit 4
    d0 = dv_n; f0 = ferr_n;
    send(8'hC3, CPB, 1'b1, 4);
    last_good = 8'h00;
    chk_reset_vals("t5_after_rst");
    tick(3 * CPB);
    chk("t5_no_dv", dv_n - d0, 0);
    chk("t5_no_ferr", ferr_n - f0, 0);
    chk("t5_byte_reset", o_RX_Byte, last_good);
    send(8'h12, CPB, 1'b1, -1);
    tick(2 * CPB);
    drain("t5");

    // Baud mismatch of about +/-3%
    f0 = ferr_n;
    send(8'h96, 210, 1'b1, -1);
    tick(2 * CPB);
    send(8'h96, 224, 1'b1, -1);
    tick(2 * CPB);
    chk("t6_ferr", ferr_n - f0, 0);
    drain("t6");

    // Random bytes, random baud skew and idle gaps
    f0 = ferr_n;
    for (int k = 0; k < 12; k++) begin
      rb = 8'($urandom);
      rc = int'($urandom_range(222, 212));
      send(rb, rc, 1'b1, -1);
      tick(int'($urandom_range(300, 0)));
    end
    tick(2 * CPB);
    chk("rand_ferr", ferr_n - f0, 0);
    drain("rand");

    chk("dv_ferr_exclusive", excl_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
